// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared types and helpers for the 1-to-4 demux family
package demux_pkg;
  typedef enum logic {IDLE, SEND} state_t;

  localparam int NOUT = 4;

  // Destination k drives bit 3-k, so index 0 maps to the MSB.
  function automatic logic [3:0] idx2onehot(input logic [1:0] k);
    return 4'b1000 >> k;
  endfunction
endpackage

// File: rtl/demux_sched_if.sv
// rtl/demux_sched_if.sv - upstream and fan-out handshake bundle for demux_sched
interface demux_sched_if #(parameter int W = 8);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotate-priority picker: first enabled index after ptr
module rr_pick
  import demux_pkg::*;
(
  input  logic [3:0] en,
  input  logic [1:0] ptr,
  output logic [1:0] k,
  output logic       any
);
  logic [1:0] j;

  // Scan from farthest to nearest so the nearest enabled index wins.
  always_comb begin
    k   = '0;
    any = 1'b0;
    j   = '0;
    for (int i = NOUT; i >= 1; i--) begin
      j = ptr + 2'(i);
      if (en[2'd3 - j]) begin
        k   = j;
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/demux_sched.sv
// rtl/demux_sched.sv - registered 1-to-4 dispatch with round-robin/directed select and timeout drop
module demux_sched
  import demux_pkg::*;
#(
  parameter int W       = 8,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mode,
  input  logic [1:0]   s,
  input  logic [3:0]   en,
  demux_sched_if.slave bus,
  output logic         drop,
  output logic         busy
);
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t       state, state_nx;
  logic [1:0]   k_q, k_nx, ptr_q, ptr_nx, pick_ptr, rr_k, new_k;
  logic [7:0]   cnt_q, cnt_nx;
  logic [3:0]   ov_q;
  logic [W-1:0] data_q;
  logic         drop_q, drop_nx, busy_q, load, rr_any, new_ok, accept, xfer;

  // A transfer this cycle moves ptr to k, so the next pick already starts from k.
  assign pick_ptr = (state == SEND) ? k_q : ptr_q;

  rr_pick u_pick (.en(en), .ptr(pick_ptr), .k(rr_k), .any(rr_any));

  assign new_k        = mode ? s : rr_k;
  assign new_ok       = mode ? en[2'd3 - s] : rr_any;
  assign xfer         = (state == SEND) && bus.out_ready[2'd3 - k_q];
  assign bus.in_ready = (state == IDLE) ? (mode || (en != 4'b0000))
                                        : bus.out_ready[2'd3 - k_q];
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    state_nx = state;
    k_nx     = k_q;
    ptr_nx   = ptr_q;
    cnt_nx   = cnt_q;
    drop_nx  = 1'b0;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          load = 1'b1;
          if (new_ok) begin
            state_nx = SEND;
            k_nx     = new_k;
            cnt_nx   = '0;
          end else begin
            drop_nx = 1'b1;
          end
        end
      end
      SEND: begin
        if (xfer) begin
          ptr_nx = k_q;
          cnt_nx = '0;
          if (accept && new_ok) begin
            load = 1'b1;
            k_nx = new_k;
          end else begin
            state_nx = IDLE;
            if (accept) begin
              load    = 1'b1;
              drop_nx = 1'b1;
            end
          end
        end else if (cnt_q == CNT_LAST) begin
          state_nx = IDLE;
          drop_nx  = 1'b1;
          ptr_nx   = k_q;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_q + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      k_q    <= '0;
      ptr_q  <= 2'd3;
      cnt_q  <= '0;
      ov_q   <= '0;
      data_q <= '0;
      drop_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nx;
      k_q    <= k_nx;
      ptr_q  <= ptr_nx;
      cnt_q  <= cnt_nx;
      ov_q   <= (state_nx == SEND) ? idx2onehot(k_nx) : 4'b0000;
      drop_q <= drop_nx;
      busy_q <= (state_nx == SEND);
      if (load) data_q <= bus.in_data;
    end
  end

  assign bus.out_valid = ov_q;
  assign bus.out_data  = data_q;
  assign drop          = drop_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_demux_sched.sv
// tb/tb_demux_sched.sv - randomized self-checking bench for demux_sched against a word-level model
module tb_demux_sched;
  localparam int W       = 8;
  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode = 1'b0;
  logic [1:0] s = 2'd0;
  logic [3:0] en = 4'b1111;
  logic       drop, busy;

  demux_sched_if #(.W(W)) bus ();

  demux_sched #(.W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .mode(mode), .s(s), .en(en),
    .bus(bus), .drop(drop), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Word-level model: a held word with its destination and how long it has been shown.
  bit         m_have;
  int         m_dest, m_age, m_last_dest;
  logic [7:0] m_word, m_shown;
  bit         m_drop;
  int         n_acc, n_del, n_drp;

  function automatic void model_reset();
    m_have = 0; m_dest = 0; m_age = 0; m_last_dest = 3;
    m_word = 8'h00; m_shown = 8'h00; m_drop = 0;
  endfunction

  function automatic bit dest_on(input logic [3:0] e, input int d);
    return e[3-d];
  endfunction

  function automatic bit model_ready(input bit m, input logic [3:0] e, input logic [3:0] ordy);
    if (m_have) return ordy[3-m_dest];
    return m || (e != 4'b0000);
  endfunction

  function automatic void model_edge(input bit iv, input logic [7:0] d, input bit m,
                                     input logic [1:0] sv, input logic [3:0] e,
                                     input logic [3:0] ordy);
    bit acc = iv && model_ready(m, e, ordy);
    int tgt = -1;
    m_drop = 0;
    if (m_have) begin
      if (ordy[3-m_dest]) begin
        m_last_dest = m_dest; m_have = 0; n_del++;
      end else begin
        m_age++;
        if (m_age == TIMEOUT) begin
          m_last_dest = m_dest; m_have = 0; m_drop = 1; n_drp++;
        end
      end
    end
    if (acc) begin
      n_acc++;
      m_shown = d;
      if (m) begin
        if (dest_on(e, int'(sv))) tgt = int'(sv);
      end else begin
        for (int step = 1; step <= 4 && tgt < 0; step++)
          if (dest_on(e, (m_last_dest + step) % 4)) tgt = (m_last_dest + step) % 4;
      end
      if (tgt >= 0) begin
        m_have = 1; m_dest = tgt; m_word = d; m_age = 0;
      end else begin
        m_drop = 1; n_drp++;
      end
    end
  endfunction

  // Called at a falling edge: checks registered outputs, drives inputs, checks in_ready, advances model.
  task automatic step(input bit iv, input logic [7:0] d, input bit m, input logic [1:0] sv,
                      input logic [3:0] e, input logic [3:0] ordy);
    chk("out_valid", bus.out_valid, m_have ? (4'b1000 >> m_dest) : 4'b0000);
    chk("out_data", bus.out_data, m_shown);
    chk("drop", drop, m_drop);
    chk("busy", busy, m_have);
    bus.in_valid = iv; bus.in_data = d; mode = m; s = sv; en = e; bus.out_ready = ordy;
    #1;
    chk("in_ready", bus.in_ready, model_ready(m, e, ordy));
    model_edge(iv, d, m, sv, e, ordy);
    @(negedge clk);
  endtask

  int shown_cnt;
  bit drop_seen;

  initial begin
    bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 4'b0000;
    model_reset();
    n_acc = 0; n_del = 0; n_drp = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_out_valid", bus.out_valid, 4'b0000);
    chk("rst_out_data", bus.out_data, 8'h00);
    chk("rst_drop", drop, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);

    // Back-to-back round-robin over all four destinations.
    for (int i = 0; i < 8; i++) begin
      step(1, 8'(8'h11 + i), 0, 2'd0, 4'b1111, 4'b1111);
      chk("rr_seq", bus.out_valid, 4'b1000 >> (i % 4));
      chk("rr_data", bus.out_data, 8'(8'h11 + i));
      chk("rr_in_ready", bus.in_ready, 1'b1);
    end
    step(0, 8'h00, 0, 2'd0, 4'b1111, 4'b1111);

    // Only destinations 0 and 2 enabled.
    for (int i = 0; i < 4; i++) begin
      step(1, 8'(8'h30 + i), 0, 2'd0, 4'b1010, 4'b1111);
      chk("rr_alt", bus.out_valid, (i % 2 == 0) ? 4'b1000 : 4'b0010);
    end
    step(0, 8'h00, 0, 2'd0, 4'b0000, 4'b1111);
    step(0, 8'h00, 0, 2'd0, 4'b0000, 4'b1111);
    chk("rr_en0_ready", bus.in_ready, 1'b0);

    // Directed delivery, then directed to a disabled destination.
    step(1, 8'hA5, 1, 2'b01, 4'b1111, 4'b0000);
    chk("dir_valid", bus.out_valid, 4'b0100);
    chk("dir_data", bus.out_data, 8'hA5);
    step(0, 8'h00, 1, 2'b01, 4'b1111, 4'b0100);
    step(1, 8'h5A, 1, 2'b11, 4'b1110, 4'b1111);
    chk("dir_dis_drop", drop, 1'b1);
    chk("dir_dis_valid", bus.out_valid, 4'b0000);
    step(0, 8'h00, 1, 2'b11, 4'b1110, 4'b1111);
    chk("dir_dis_pulse", drop, 1'b0);

    // Stall until timeout.
    step(1, 8'hC3, 1, 2'b10, 4'b1111, 4'b0000);
    shown_cnt = 0; drop_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid != 4'b0000) shown_cnt++;
      if (drop) drop_seen = 1;
      step(0, 8'h00, 1, 2'b10, 4'b1111, 4'b0000);
    end
    chk("to_shown", shown_cnt, TIMEOUT);
    chk("to_drop", drop_seen, 1'b1);

    // Ready in the last presented cycle wins over the timeout.
    step(1, 8'h3C, 1, 2'b10, 4'b1111, 4'b0000);
    for (int i = 1; i < TIMEOUT; i++) step(0, 8'h00, 1, 2'b10, 4'b1111, 4'b0000);
    chk("last_valid", bus.out_valid, 4'b0010);
    step(0, 8'h00, 1, 2'b10, 4'b1111, 4'b0010);
    chk("last_nodrop", drop, 1'b0);
    chk("last_idle", bus.out_valid, 4'b0000);

    // Randomized traffic with randomly toggling readiness.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom),
           2'($urandom), ($urandom_range(0, 15) == 0) ? 4'b0000 : 4'($urandom),
           ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom));
    end
    chk("conserve", n_acc, n_del + n_drp + int'(m_have));

    // Asynchronous reset while a word is held.
    step(1, 8'h77, 1, 2'b11, 4'b1111, 4'b0000);
    chk("pre_rst_busy", busy, 1'b1);
    #2 rst = 1;
    #1;
    chk("arst_valid", bus.out_valid, 4'b0000);
    chk("arst_busy", busy, 1'b0);
    chk("arst_drop", drop, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 0;
    step(1, 8'h99, 0, 2'd0, 4'b1111, 4'b1111);
    chk("arst_first_rr", bus.out_valid, 4'b1000);
    step(0, 8'h00, 0, 2'd0, 4'b1111, 4'b1111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
